datapath_pipe: RTL and testbench

DATAPATH_PIPE -- requirements
Module: datapath_pipe

---
 rtl/osecpu_pkg.sv | 73 +++++++
 rtl/datapath_hazard.sv | 41 ++++
 rtl/datapath_pipe.sv | 147 ++++++++++++++
 tb/tb_datapath_pipe.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/osecpu_pkg.sv
// Shared OSECPU definitions: opcode map, instruction field layout and decode helpers
// used by the datapath pipeline and its hazard unit.
package osecpu_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned OPF_W    = 8;
  localparam int unsigned REGF_W   = 6;
  localparam int unsigned IMM_W    = 16;
  localparam int unsigned OP_LSB   = 24;
  localparam int unsigned OPD0_LSB = 18;
  localparam int unsigned OPD1_LSB = 12;
  localparam int unsigned OPD2_LSB = 6;
  localparam int unsigned IMM_LSB  = 0;

  localparam logic [OPF_W-1:0] OP_LBSET  = 8'h01;
  localparam logic [OPF_W-1:0] OP_LIMM16 = 8'h02;
  localparam logic [OPF_W-1:0] OP_LIMM32 = 8'h03;
  localparam logic [OPF_W-1:0] OP_CP     = 8'h04;
  localparam logic [OPF_W-1:0] OP_CPDR   = 8'h05;
  localparam logic [OPF_W-1:0] OP_OR     = 8'h10;
  localparam logic [OPF_W-1:0] OP_XOR    = 8'h11;
  localparam logic [OPF_W-1:0] OP_AND    = 8'h12;
  localparam logic [OPF_W-1:0] OP_ADD    = 8'h14;
  localparam logic [OPF_W-1:0] OP_SUB    = 8'h15;
  localparam logic [OPF_W-1:0] OP_SHL    = 8'h18;
  localparam logic [OPF_W-1:0] OP_SAR    = 8'h19;

  typedef enum logic [2:0] {
    K_NOP, K_IMM16, K_IMM32, K_CP, K_CPDR, K_ALU
  } kind_t;

  typedef struct packed {
    logic [OPF_W-1:0]  op;
    logic [REGF_W-1:0] opd0;
    logic [REGF_W-1:0] opd1;
    logic [REGF_W-1:0] opd2;
    logic [IMM_W-1:0]  imm16;
  } instr_t;

  function automatic instr_t decode(input logic [INSTR_W-1:0] w);
    instr_t d;
    d.op    = w[OP_LSB +: OPF_W];
    d.opd0  = w[OPD0_LSB +: REGF_W];
    d.opd1  = w[OPD1_LSB +: REGF_W];
    d.opd2  = w[OPD2_LSB +: REGF_W];
    d.imm16 = w[IMM_LSB +: IMM_W];
    return d;
  endfunction

  function automatic kind_t op_kind(input logic [OPF_W-1:0] op);
    case (op)
      OP_LBSET, OP_LIMM16: return K_IMM16;
      OP_LIMM32:           return K_IMM32;
      OP_CP:               return K_CP;
      OP_CPDR:             return K_CPDR;
      OP_OR, OP_XOR, OP_AND, OP_ADD, OP_SUB, OP_SHL, OP_SAR: return K_ALU;
      default:             return K_NOP;
    endcase
  endfunction

  function automatic logic kind_writes(input kind_t k);
    return (k == K_IMM16) || (k == K_IMM32) || (k == K_CP) || (k == K_ALU);
  endfunction

  function automatic logic kind_uses1(input kind_t k);
    return (k == K_CP) || (k == K_CPDR) || (k == K_ALU);
  endfunction

  function automatic logic kind_uses2(input kind_t k);
    return k == K_ALU;
  endfunction

endpackage

// File: rtl/datapath_hazard.sv
// RAW hazard detection and operand forwarding for the A stage.
// DATAPATH_FWD_EN selects zero-stall forwarding; otherwise hazards stall.
module datapath_hazard #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 6
) (
  input  logic [RADDR_W-1:0] i_src1,
  input  logic [RADDR_W-1:0] i_src2,
  input  logic               i_uses1,
  input  logic               i_uses2,
  input  logic               i_ex_wr,
  input  logic [RADDR_W-1:0] i_ex_rd,
  input  logic [DATA_W-1:0]  i_ex_res,
  input  logic               i_wb_we,
  input  logic [RADDR_W-1:0] i_wb_rw,
  input  logic [DATA_W-1:0]  i_wb_dw,
  input  logic [DATA_W-1:0]  i_rd0,
  input  logic [DATA_W-1:0]  i_rd1,
  output logic               o_stall_c,
  output logic [DATA_W-1:0]  o_d0_c,
  output logic [DATA_W-1:0]  o_d1_c
);

  logic w_ex_hit1, w_ex_hit2, w_wb_hit1, w_wb_hit2;

  assign w_ex_hit1 = i_uses1 & i_ex_wr & (i_src1 == i_ex_rd);
  assign w_ex_hit2 = i_uses2 & i_ex_wr & (i_src2 == i_ex_rd);
  assign w_wb_hit1 = i_uses1 & i_wb_we & (i_src1 == i_wb_rw);
  assign w_wb_hit2 = i_uses2 & i_wb_we & (i_src2 == i_wb_rw);

  // EX holds the younger value, so it wins over WB; without forwarding no hit survives to accept.
  assign o_d0_c = w_ex_hit1 ? i_ex_res : (w_wb_hit1 ? i_wb_dw : i_rd0);
  assign o_d1_c = w_ex_hit2 ? i_ex_res : (w_wb_hit2 ? i_wb_dw : i_rd1);

`ifdef DATAPATH_FWD_EN
  assign o_stall_c = 1'b0;
`else
  assign o_stall_c = w_ex_hit1 | w_ex_hit2 | w_wb_hit1 | w_wb_hit2;
`endif

endmodule

// File: rtl/datapath_pipe.sv
// Three-stage OSECPU datapath (accept/read, EX, WB) with RAW hazard handling.
// Define DATAPATH_FWD_EN for zero-stall operand forwarding.
module datapath_pipe
  import osecpu_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 6,
  parameter int unsigned OPC_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        instr0,
  input  logic [31:0]        instr1,
  output logic [RADDR_W-1:0] ireg_r0,
  output logic [RADDR_W-1:0] ireg_r1,
  input  logic [DATA_W-1:0]  ireg_d0,
  input  logic [DATA_W-1:0]  ireg_d1,
  output logic [DATA_W-1:0]  alu_d0,
  output logic [DATA_W-1:0]  alu_d1,
  output logic [3:0]         alu_op,
  input  logic [DATA_W-1:0]  alu_dout,
  output logic [RADDR_W-1:0] ireg_rw,
  output logic [DATA_W-1:0]  ireg_dw,
  output logic               ireg_we,
  output logic               dr_valid,
  output logic [DATA_W-1:0]  dr_data
);

  instr_t             w_dec;
  logic [OPC_W-1:0]   w_op;
  kind_t              w_kind;
  logic [RADDR_W-1:0] w_dst;
  logic               w_hz_stall, w_acc;
  logic [DATA_W-1:0]  w_fd0, w_fd1;
  logic [DATA_W-1:0]  w_ex_d0_n, w_ex_d1_n;
  logic [3:0]         w_ex_op_n;

  logic               r_ex_valid;
  kind_t              r_ex_kind;
  logic [RADDR_W-1:0] r_ex_rd;
  logic [DATA_W-1:0]  r_ex_d0, r_ex_d1;
  logic [3:0]         r_ex_op;
  logic               w_ex_wr, w_ex_dr;
  logic [DATA_W-1:0]  w_ex_res;

  logic               r_wb_we, r_dr_valid;
  logic [RADDR_W-1:0] r_wb_rw;
  logic [DATA_W-1:0]  r_wb_dw, r_dr_data;

  assign w_dec   = decode(instr0);
  assign w_op    = OPC_W'(w_dec.op);
  assign w_kind  = op_kind(OPF_W'(w_op));
  assign w_dst   = RADDR_W'(w_dec.opd0);
  assign ireg_r0 = RADDR_W'(w_dec.opd1);
  assign ireg_r1 = RADDR_W'(w_dec.opd2);

  assign in_ready = ~(in_valid & w_hz_stall);
  assign w_acc    = in_valid & in_ready;

  datapath_hazard #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_hazard (
    .i_src1   (ireg_r0),
    .i_src2   (ireg_r1),
    .i_uses1  (kind_uses1(w_kind)),
    .i_uses2  (kind_uses2(w_kind)),
    .i_ex_wr  (w_ex_wr),
    .i_ex_rd  (r_ex_rd),
    .i_ex_res (w_ex_res),
    .i_wb_we  (r_wb_we),
    .i_wb_rw  (r_wb_rw),
    .i_wb_dw  (r_wb_dw),
    .i_rd0    (ireg_d0),
    .i_rd1    (ireg_d1),
    .o_stall_c(w_hz_stall),
    .o_d0_c   (w_fd0),
    .o_d1_c   (w_fd1)
  );

  // EX operand selection; a non-ALU result rides in d0 with alu_op left at 0.
  always_comb begin
    w_ex_d0_n = '0;
    w_ex_d1_n = '0;
    w_ex_op_n = '0;
    if (w_acc) begin
      case (w_kind)
        K_IMM16:      w_ex_d0_n = DATA_W'($signed(w_dec.imm16));
        K_IMM32:      w_ex_d0_n = DATA_W'(instr1);
        K_CP, K_CPDR: w_ex_d0_n = w_fd0;
        K_ALU: begin
          w_ex_d0_n = w_fd0;
          w_ex_d1_n = w_fd1;
          w_ex_op_n = 4'(w_op);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid <= 1'b0;
      r_ex_kind  <= K_NOP;
      r_ex_rd    <= '0;
      r_ex_d0    <= '0;
      r_ex_d1    <= '0;
      r_ex_op    <= '0;
    end else begin
      r_ex_valid <= w_acc;
      r_ex_kind  <= w_acc ? w_kind : K_NOP;
      r_ex_rd    <= w_acc ? w_dst : '0;
      r_ex_d0    <= w_ex_d0_n;
      r_ex_d1    <= w_ex_d1_n;
      r_ex_op    <= w_ex_op_n;
    end
  end

  assign alu_d0   = r_ex_d0;
  assign alu_d1   = r_ex_d1;
  assign alu_op   = r_ex_op;
  assign w_ex_wr  = r_ex_valid & kind_writes(r_ex_kind);
  assign w_ex_dr  = r_ex_valid & (r_ex_kind == K_CPDR);
  assign w_ex_res = (r_ex_kind == K_ALU) ? alu_dout : r_ex_d0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_we    <= 1'b0;
      r_wb_rw    <= '0;
      r_wb_dw    <= '0;
      r_dr_valid <= 1'b0;
      r_dr_data  <= '0;
    end else begin
      r_wb_we    <= w_ex_wr;
      r_wb_rw    <= w_ex_wr ? r_ex_rd : '0;
      r_wb_dw    <= w_ex_wr ? w_ex_res : '0;
      r_dr_valid <= w_ex_dr;
      r_dr_data  <= w_ex_dr ? w_ex_res : '0;
    end
  end

  assign ireg_we  = r_wb_we;
  assign ireg_rw  = r_wb_rw;
  assign ireg_dw  = r_wb_dw;
  assign dr_valid = r_dr_valid;
  assign dr_data  = r_dr_data;

endmodule

// File: tb/tb_datapath_pipe.sv
// Scoreboard bench for datapath_pipe: directed instruction vectors, register file
// and ALU models around the DUT, and a monitor that checks every WB/debug-read event.
module tb_datapath_pipe;
  import osecpu_pkg::*;

`ifdef DATAPATH_FWD_EN
  localparam int HZ = 0;
`else
  localparam int HZ = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready;
  logic [31:0] instr0, instr1;
  logic [5:0]  ireg_r0, ireg_r1, ireg_rw;
  logic [31:0] ireg_d0, ireg_d1, alu_d0, alu_d1, alu_dout, ireg_dw, dr_data;
  logic [3:0]  alu_op;
  logic        ireg_we, dr_valid;

  typedef struct {
    logic        is_dr;
    logic [5:0]  rw;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [31:0] rf [64];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  datapath_pipe #(.DATA_W(32), .RADDR_W(6), .OPC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr0(instr0), .instr1(instr1), .ireg_r0(ireg_r0), .ireg_r1(ireg_r1),
    .ireg_d0(ireg_d0), .ireg_d1(ireg_d1), .alu_d0(alu_d0), .alu_d1(alu_d1),
    .alu_op(alu_op), .alu_dout(alu_dout), .ireg_rw(ireg_rw), .ireg_dw(ireg_dw),
    .ireg_we(ireg_we), .dr_valid(dr_valid), .dr_data(dr_data)
  );

  // Register file: same-cycle read of old contents, commit at clock edge
  assign ireg_d0 = rf[ireg_r0];
  assign ireg_d1 = rf[ireg_r1];
  always @(posedge clk) if (ireg_we) rf[ireg_rw] <= ireg_dw;

  always_comb begin
    case (alu_op)
      4'h0:    alu_dout = alu_d0 | alu_d1;
      4'h1:    alu_dout = alu_d0 ^ alu_d1;
      4'h2:    alu_dout = alu_d0 & alu_d1;
      4'h4:    alu_dout = alu_d0 + alu_d1;
      4'h5:    alu_dout = alu_d0 - alu_d1;
      4'h8:    alu_dout = alu_d0 << alu_d1[4:0];
      4'h9:    alu_dout = 32'($signed(alu_d0) >>> alu_d1[4:0]);
      default: alu_dout = '0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [7:0] op, input logic [5:0] a,
                                        input logic [5:0] b, input logic [5:0] c);
    return {op, a, b, c, 6'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [7:0] op, input logic [5:0] a,
                                        input logic [15:0] imm);
    return {op, a, 2'b00, imm};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one instruction pair; expected WB lands stall+2 cycles after presentation.
  task automatic send(input string name, input logic [31:0] i0, input logic [31:0] i1,
                      input int stall, input bit has_exp, input bit is_dr,
                      input logic [5:0] rw, input logic [31:0] data);
    int   st;
    exp_t e;
    if (has_exp) begin
      e.is_dr = is_dr; e.rw = rw; e.data = data; e.cyc = cyc + stall + 2;
      sb.push_back(e);
    end
    in_valid = 1'b1; instr0 = i0; instr1 = i1;
    st = 0;
    @(negedge clk);
    while (!in_ready && st < 6) begin
      st++;
      @(negedge clk);
    end
    chk({name, "_stall"}, 32'(st), 32'(stall));
    @(posedge clk); #1;
    in_valid = 1'b0; instr0 = '0; instr1 = '0;
  endtask

  task automatic wr(input string name, input logic [31:0] i0, input logic [31:0] i1,
                    input int stall, input logic [5:0] rw, input logic [31:0] data);
    send(name, i0, i1, stall, 1'b1, 1'b0, rw, data);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && (ireg_we || dr_valid)) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_wb: got we=%0b dr=%0b rw=%0d dw=0x%08h, required no output (cycle %0d)",
                 ireg_we, dr_valid, ireg_rw, ireg_dw, cyc);
      end else begin
        e = sb.pop_front();
        chk("wb_kind", {30'd0, ireg_we, dr_valid}, e.is_dr ? 32'd1 : 32'd2);
        chk("wb_cycle", 32'(cyc), 32'(e.cyc));
        if (e.is_dr) chk("dr_data", dr_data, e.data);
        else begin
          chk("wb_rw", 32'(ireg_rw), 32'(e.rw));
          chk("wb_dw", ireg_dw, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; instr0 = '0; instr1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_we", 32'(ireg_we), 0);
    chk("rst_rw", 32'(ireg_rw), 0);
    chk("rst_dw", ireg_dw, 0);
    chk("rst_alu_d0", alu_d0, 0);
    chk("rst_alu_d1", alu_d1, 0);
    chk("rst_alu_op", 32'(alu_op), 0);
    chk("rst_dr_valid", 32'(dr_valid), 0);
    chk("rst_dr_data", dr_data, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(in_ready), 1);
    idle(1);

    wr("limm16_neg", enc_i(OP_LIMM16, 6'd1, 16'h8000), '0, 0, 6'd1, 32'hFFFF8000);
    idle(4);

    wr("limm16_r1", enc_i(OP_LIMM16, 6'd1, 16'd5), '0, 0, 6'd1, 32'd5);
    wr("add_dep", enc_r(OP_ADD, 6'd2, 6'd1, 6'd1), '0, HZ, 6'd2, 32'd10);
    idle(4);

    wr("limm32", enc_r(OP_LIMM32, 6'd3, 6'd0, 6'd0), 32'hDEADBEEF, 0, 6'd3, 32'hDEADBEEF);
    send("cpdr", enc_r(OP_CPDR, 6'd0, 6'd3, 6'd0), '0, HZ, 1'b1, 1'b1, 6'd0, 32'hDEADBEEF);
    idle(4);

    wr("limm_r1_3", enc_i(OP_LIMM16, 6'd1, 16'd3), '0, 0, 6'd1, 32'd3);
    wr("limm_r2_5", enc_i(OP_LIMM16, 6'd2, 16'd5), '0, 0, 6'd2, 32'd5);
    wr("sub", enc_r(OP_SUB, 6'd4, 6'd1, 6'd2), '0, HZ, 6'd4, 32'hFFFFFFFE);
    @(negedge clk);
    chk("sub_alu_op", 32'(alu_op), 32'h5);
    chk("sub_alu_d0", alu_d0, 32'd3);
    chk("sub_alu_d1", alu_d1, 32'd5);
    idle(4);

    // Independent ALU/copy burst at full rate
    wr("or",    enc_r(OP_OR,  6'd5,  6'd1, 6'd2), '0, 0, 6'd5,  32'h00000007);
    wr("xor",   enc_r(OP_XOR, 6'd6,  6'd3, 6'd2), '0, 0, 6'd6,  32'hDEADBEEA);
    wr("and",   enc_r(OP_AND, 6'd7,  6'd3, 6'd4), '0, 0, 6'd7,  32'hDEADBEEE);
    wr("shl",   enc_r(OP_SHL, 6'd8,  6'd2, 6'd1), '0, 0, 6'd8,  32'h00000028);
    wr("sar",   enc_r(OP_SAR, 6'd9,  6'd4, 6'd1), '0, 0, 6'd9,  32'hFFFFFFFF);
    wr("cp",    enc_r(OP_CP,  6'd10, 6'd3, 6'd0), '0, 0, 6'd10, 32'hDEADBEEF);
    wr("lbset", enc_i(OP_LBSET, 6'd11, 16'h1234), '0, 0, 6'd11, 32'h00001234);
    idle(4);

    wr("limm_r0", enc_i(OP_LIMM16, 6'd0, 16'd7), '0, 0, 6'd0, 32'd7);
    wr("cp_r0", enc_r(OP_CP, 6'd12, 6'd0, 6'd0), '0, HZ, 6'd12, 32'd7);
    idle(4);

    send("unknown", enc_r(8'hFF, 6'd1, 6'd1, 6'd1), '0, 0, 1'b0, 1'b0, 6'd0, '0);
    idle(4);

    // Two instructions in flight when reset hits: nothing may retire afterwards
    send("rst_a", enc_i(OP_LIMM16, 6'd13, 16'd1), '0, 0, 1'b0, 1'b0, 6'd0, '0);
    send("rst_b", enc_i(OP_LIMM16, 6'd14, 16'd2), '0, 0, 1'b0, 1'b0, 6'd0, '0);
    chk("inflight_we", 32'(ireg_we), 1);
    chk("inflight_alu_d0", alu_d0, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("midrst_we", 32'(ireg_we), 0);
    chk("midrst_rw", 32'(ireg_rw), 0);
    chk("midrst_dw", ireg_dw, 0);
    chk("midrst_alu_d0", alu_d0, 0);
    chk("midrst_dr_valid", 32'(dr_valid), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(6);
    chk("ready_end", 32'(in_ready), 1);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
